tdm_shift_out: RTL
==================

// Module: tdm_shift_out
// PURPOSE
//  Parametrised parallel-in/serial-out audio transmitter; successor to the 2-ch mux/shift output stage.
//  Takes one frame of NUM_CH beamformed samples per valid/ready handshake.
//  Generates the bit clock (sclk), frame clock (lr_clk) and serial data (sd) internally from clk.
//  Sits at the tail of the mic-array pipeline, after summation; drives an I2S/TDM sink.
//  Adds over the previous stage: configurable channel count, sample and slot width, and I2S vs left-justified timing.
//  Adds a one-deep holding buffer with handshake and underrun reporting.
// PARAMETERS
//  DATA_W    24  sample width, two's complement, transmitted MSB first
//  SLOT_W    32  sclk bits per channel slot; DATA_W+MSB_DELAY <= SLOT_W
//  NUM_CH    2   channels per frame; even, >= 2
//  CLK_DIV   4   clk cycles per sclk bit; even, >= 2
//  MSB_DELAY 1   1 = I2S (MSB one bit after slot start), 0 = left-justified
// PORTS
//  clk         in   1              system clock; all logic on rising edge
//  rst         in   1              synchronous reset, active-high
//  en          in   1              serializer enable
//  in_valid    in   1              in_data holds a complete frame
//  in_ready    out  1              holding buffer empty; transfer when in_valid & in_ready
//  in_data     in   NUM_CH*DATA_W  ch0 in [DATA_W-1:0], chN in [(N+1)*DATA_W-1:N*DATA_W]
//  sclk        out  1              bit clock
//  lr_clk      out  1              frame clock: 0 for slots 0..NUM_CH/2-1, 1 for the rest
//  sd          out  1              serial data; changes at sclk falling edge, sink samples on rising edge
//  frame_start out  1              1-cycle pulse when frame bit 0 begins
//  underrun    out  1              1-cycle pulse, coincident with frame_start, when no frame was buffered
// BEHAVIOUR
//  Reset: sclk=lr_clk=sd=frame_start=underrun=0; in_ready=1; hold empty; counters 0. Takes priority over en.
//  Counters:
//   - div_cnt 0..CLK_DIV-1.
//   - bit_cnt 0..SLOT_W*NUM_CH-1; advances when div_cnt wraps, and wraps to 0 at the end of the frame.
//   - slot = bit_cnt/SLOT_W; b = bit_cnt%SLOT_W.
//  All outputs are registered:
//   - The first cycle with en=1 (from idle) is frame bit 0, div_cnt=0.
//   - frame_start is high in the cycle after that first cycle.
//   - sd, lr_clk and sclk show bit 0 in that same cycle.
//  sclk = 0 for div_cnt < CLK_DIV/2, else 1. Bit period = CLK_DIV cycles; frame = CLK_DIV*SLOT_W*NUM_CH cycles.
//  Data mapping: k = b - MSB_DELAY.
//   - If 0 <= k < DATA_W: sd = sample[slot][DATA_W-1-k].
//   - Otherwise sd = 0 (padding).
//  lr_clk changes at slot 0 bit 0 and slot NUM_CH/2 bit 0. With MSB_DELAY=1 this falls one bit before the MSB (I2S).
//  Holding buffer:
//   - An accepted frame sets hold_full; in_ready = ~hold_full (registered).
//   - At each frame bit 0 the shift register loads from hold if full, and hold_full clears.
//   - If hold is empty at that point, the shift register loads all zeros and underrun pulses.
//  Simultaneous accept and frame load while hold is empty: the load sees empty (underrun, zeros). The accepted frame is held for the next frame.
//  Back-to-back: in_ready returns to 1 one cycle after the frame_start that consumed hold.
//  en deasserted mid-frame:
//   - Next cycle sclk=lr_clk=sd=0 and counters go to 0; the frame is aborted.
//   - hold is retained and accepts continue.
//   - Re-enable restarts at frame bit 0. The aborted shift-register frame is lost; no underrun is raised for it.
//  rst mid-frame: immediate return to reset state; the held frame is discarded.
// TESTING (defaults unless stated; frame = 64 bits = 256 clk)
//  1. rst=1 for 5 cycles, in_valid=0 -> sclk=lr_clk=sd=0, in_ready=1, frame_start=underrun=0.
//  2. Push ch0=24'hA5A5A5, ch1=24'h3C3C3C, then en=1:
//     - slot 0: bit 0 sd=0; bits 1..24 = A5A5A5 MSB first; bits 25..31 = 0; lr_clk=0.
//     - slot 1: lr_clk=1 from bit 32; 3C3C3C in bits 33..56.
//  3. No second push -> next frame_start has underrun=1 and sd=0 for all 64 bits; in_ready stays 1.
//  4. Push two frames back-to-back:
//     - second waits while in_ready=0;
//     - in_ready=1 one cycle after the frame_start that loaded the first;
//     - the second frame is transmitted next with no underrun.
//  5. NUM_CH=4, MSB_DELAY=0, CLK_DIV=2, samples 24'h800001..24'h800004:
//     - lr_clk low for slots 0-1, high for slots 2-3;
//     - each MSB on slot bit 0;
//     - sclk period 2 cycles.
//  6. en=0 at frame bit 10 -> outputs 0 next cycle; re-enable restarts at bit 0 with the buffered frame.
//     rst at bit 40 -> in_ready=1 and the next frame underruns.

Source files
------------

// File: rtl/tdm_shift_out.sv
// Parallel-in/serial-out I2S/TDM transmitter with a one-deep frame holding buffer.
// Generates sclk, lr_clk and sd from clk; all outputs are registered.
module tdm_shift_out #(
    parameter int DATA_W    = 24,
    parameter int SLOT_W    = 32,
    parameter int NUM_CH    = 2,
    parameter int CLK_DIV   = 4,
    parameter int MSB_DELAY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     sclk,
    output logic                     lr_clk,
    output logic                     sd,
    output logic                     frame_start,
    output logic                     underrun
);

    localparam int FRAME_BITS = SLOT_W * NUM_CH;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int FRM_W      = NUM_CH * DATA_W;
    localparam int IDX_W      = $clog2(FRM_W);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             hold_full_q, hold_full_d;
    logic             in_ready_q, in_ready_d;
    logic [FRM_W-1:0] hold_q, hold_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic             sclk_q, sclk_d;
    logic             lr_clk_q, lr_clk_d;
    logic             sd_q, sd_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;

    logic             accept;
    logic             load;
    logic [FRM_W-1:0] cur_frame;
    int               slot_i;
    int               k_i;

    always_comb begin
        accept    = in_valid & in_ready_q;
        load      = en & (div_cnt_q == '0) & (bit_cnt_q == '0);
        // The frame register is loaded at bit 0, but bit 0 must already be
        // presented from the incoming frame, so the load value bypasses it.
        cur_frame = load ? (hold_full_q ? hold_q : '0) : frame_q;
        slot_i    = int'(bit_cnt_q) / SLOT_W;
        k_i       = int'(bit_cnt_q) % SLOT_W - MSB_DELAY;

        hold_d        = accept ? in_data : hold_q;
        hold_full_d   = load ? accept : (hold_full_q | accept);
        in_ready_d    = ~hold_full_q & ~accept;
        frame_d       = cur_frame;

        div_cnt_d     = '0;
        bit_cnt_d     = '0;
        sclk_d        = 1'b0;
        lr_clk_d      = 1'b0;
        sd_d          = 1'b0;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (en) begin
            if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
                div_cnt_d = '0;
                bit_cnt_d = (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
                bit_cnt_d = bit_cnt_q;
            end
            sclk_d        = (div_cnt_q >= DIV_W'(CLK_DIV / 2));
            lr_clk_d      = (slot_i >= NUM_CH / 2);
            if (k_i >= 0 && k_i < DATA_W) begin
                sd_d = cur_frame[IDX_W'(slot_i * DATA_W + DATA_W - 1 - k_i)];
            end
            frame_start_d = load;
            underrun_d    = load & ~hold_full_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            hold_full_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            sclk_q        <= 1'b0;
            lr_clk_q      <= 1'b0;
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_full_q   <= hold_full_d;
            in_ready_q    <= in_ready_d;
            sclk_q        <= sclk_d;
            lr_clk_q      <= lr_clk_d;
            sd_q          <= sd_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    // Sample storage carries no reset; hold_full_q qualifies its contents.
    always_ff @(posedge clk) begin
        hold_q  <= hold_d;
        frame_q <= frame_d;
    end

    assign in_ready    = in_ready_q;
    assign sclk        = sclk_q;
    assign lr_clk      = lr_clk_q;
    assign sd          = sd_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule
